// File: rtl/bus_frame_receiver.sv
// bus_frame_receiver: samples the shared data bus while dcontrol is high,
// acknowledges each accepted word combinationally, buffers words in a
// first-word-fall-through FIFO and reports length/status per frame.
module bus_frame_receiver #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          bus,
    input  logic                       dcontrol,
    output logic                       ack,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       frame_done,
    output logic [LEN_W-1:0]           frame_len,
    output logic                       frame_err
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                frame_done_q, frame_done_d;
    logic [LEN_W-1:0]    frame_len_q, frame_len_d;
    logic                frame_err_q, frame_err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                rd_valid_q;

    logic                pop;
    logic                can_push;
    logic                push;
    logic [LEN_W-1:0]    cnt_inc;

    // Handshake terms; a full FIFO still accepts a word when the head leaves this cycle.
    assign pop      = rd_valid_q && rd_ready;
    assign can_push = (level_q < LVL_W'(DEPTH)) || ((level_q == LVL_W'(DEPTH)) && pop);
    assign ack      = rst_n && dcontrol && can_push && (state_q != DROP);
    assign push     = ack;
    assign cnt_inc  = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + LEN_W'(1);
    assign level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

    // Frame FSM: next state, word counter and end-of-frame report.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        frame_err_d  = frame_err_q;
        unique case (state_q)
            IDLE: begin
                if (dcontrol) begin
                    if (can_push) begin
                        cnt_d   = LEN_W'(1);
                        state_d = RECV;
                    end else begin
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = DROP;
                    end
                end
            end
            RECV: begin
                if (dcontrol) begin
                    if (can_push) begin
                        cnt_d = cnt_inc;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DROP;
                    end
                end else begin
                    frame_done_d = 1'b1;
                    frame_len_d  = cnt_q;
                    frame_err_d  = err_q;
                    cnt_d        = '0;
                    err_d        = 1'b0;
                    state_d      = IDLE;
                end
            end
            DROP: begin
                if (!dcontrol) begin
                    frame_done_d = 1'b1;
                    frame_len_d  = cnt_q;
                    frame_err_d  = err_q;
                    cnt_d        = '0;
                    err_d        = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and frame report registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q    <= level_d;
            rd_valid_q <= (level_d != '0);
        end
    end

    assign rd_data    = mem_q[rd_ptr_q];
    assign rd_valid   = rd_valid_q;
    assign level      = level_q;
    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_bus_frame_receiver.sv
// Table-driven bench for bus_frame_receiver: each row drives one cycle's inputs
// and lists the outputs expected in that same cycle (ack is combinational,
// the rest reflect earlier edges). Asynchronous reset is checked by hand.
module tb_bus_frame_receiver;

    logic        clk;
    logic        rst_n;
    logic [31:0] bus;
    logic        dcontrol;
    logic        ack;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [2:0]  level;
    logic        frame_done;
    logic [7:0]  frame_len;
    logic        frame_err;

    bus_frame_receiver #(.DATA_W(32), .DEPTH(4), .LEN_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dcontrol   (dcontrol),
        .ack        (ack),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .level      (level),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .frame_err  (frame_err)
    );

    typedef struct {
        logic        rst_n;
        logic        dc;
        logic [31:0] bus;
        logic        rdy;
        logic        ack;
        logic        valid;
        logic        chk_data;
        logic [31:0] data;
        logic [2:0]  level;
        logic        done;
        logic [7:0]  len;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   row    = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic add(input logic r, input logic dc, input logic [31:0] b, input logic rdy,
                       input logic a, input logic v, input logic cd, input logic [31:0] d,
                       input logic [2:0] lv, input logic dn, input logic [7:0] ln, input logic er);
        vec_t x;
        x.rst_n = r; x.dc = dc; x.bus = b; x.rdy = rdy;
        x.ack = a; x.valid = v; x.chk_data = cd; x.data = d;
        x.level = lv; x.done = dn; x.len = ln; x.err = er;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h required 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic dc, input logic [31:0] b, input logic rdy);
        @(negedge clk);
        rst_n = r; dcontrol = dc; bus = b; rd_ready = rdy;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; dcontrol = 1'b0; bus = '0; rd_ready = 1'b0;

        // reset: ack forced low even with dcontrol high
        add(0,1,32'hDEAD,0, 0,0,0,0, 0,0,0,0);
        add(0,0,0,0,        0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 10; i++) add(1,0,0,0, 0,0,0,0, 0,0,0,0);

        // 3-word frame, then drain
        add(1,1,32'h11,0, 1,0,0,0,      0,0,0,0);
        add(1,1,32'h22,0, 1,1,1,32'h11, 1,0,0,0);
        add(1,1,32'h33,0, 1,1,1,32'h11, 2,0,0,0);
        add(1,0,0,0,      0,1,1,32'h11, 3,0,0,0);
        add(1,0,0,0,      0,1,1,32'h11, 3,1,3,0);
        add(1,0,0,1,      0,1,1,32'h11, 3,0,3,0);
        add(1,0,0,1,      0,1,1,32'h22, 2,0,3,0);
        add(1,0,0,1,      0,1,1,32'h33, 1,0,3,0);
        add(1,0,0,0,      0,0,0,0,      0,0,3,0);

        // 6-word frame into a 4-deep FIFO: overflow
        add(1,1,32'hA0,0, 1,0,0,0,      0,0,3,0);
        add(1,1,32'hA1,0, 1,1,1,32'hA0, 1,0,3,0);
        add(1,1,32'hA2,0, 1,1,1,32'hA0, 2,0,3,0);
        add(1,1,32'hA3,0, 1,1,1,32'hA0, 3,0,3,0);
        add(1,1,32'hA4,0, 0,1,1,32'hA0, 4,0,3,0);
        add(1,1,32'hA5,0, 0,1,1,32'hA0, 4,0,3,0);
        add(1,0,0,0,      0,1,1,32'hA0, 4,0,3,0);
        add(1,0,0,0,      0,1,1,32'hA0, 4,1,4,1);
        // full FIFO with simultaneous pop accepts 0xBB
        add(1,1,32'hBB,1, 1,1,1,32'hA0, 4,0,4,1);
        add(1,0,0,1,      0,1,1,32'hA1, 4,0,4,1);
        add(1,0,0,1,      0,1,1,32'hA2, 3,1,1,0);
        add(1,0,0,1,      0,1,1,32'hA3, 2,0,1,0);
        add(1,0,0,1,      0,1,1,32'hBB, 1,0,1,0);
        add(1,0,0,1,      0,0,0,0,      0,0,1,0);
        add(1,0,0,0,      0,0,0,0,      0,0,1,0);

        // back-to-back frames: 2 words, one idle cycle, 1 word
        add(1,1,32'hC1,0, 1,0,0,0,      0,0,1,0);
        add(1,1,32'hC2,0, 1,1,1,32'hC1, 1,0,1,0);
        add(1,0,0,0,      0,1,1,32'hC1, 2,0,1,0);
        add(1,1,32'hC3,0, 1,1,1,32'hC1, 2,1,2,0);
        add(1,0,0,0,      0,1,1,32'hC1, 3,0,2,0);
        add(1,0,0,0,      0,1,1,32'hC1, 3,1,1,0);
        add(1,0,0,1,      0,1,1,32'hC1, 3,0,1,0);
        add(1,0,0,1,      0,1,1,32'hC2, 2,0,1,0);
        add(1,0,0,1,      0,1,1,32'hC3, 1,0,1,0);
        add(1,0,0,0,      0,0,0,0,      0,0,1,0);

        // frame starting while FIFO full: dropped from IDLE, len 0 err 1
        add(1,1,32'hD0,0, 1,0,0,0,      0,0,1,0);
        add(1,1,32'hD1,0, 1,1,1,32'hD0, 1,0,1,0);
        add(1,1,32'hD2,0, 1,1,1,32'hD0, 2,0,1,0);
        add(1,1,32'hD3,0, 1,1,1,32'hD0, 3,0,1,0);
        add(1,0,0,0,      0,1,1,32'hD0, 4,0,1,0);
        add(1,1,32'hEE,0, 0,1,1,32'hD0, 4,1,4,0);
        add(1,1,32'hEF,0, 0,1,1,32'hD0, 4,0,4,0);
        add(1,0,0,0,      0,1,1,32'hD0, 4,0,4,0);
        add(1,0,0,1,      0,1,1,32'hD0, 4,1,0,1);
        add(1,0,0,1,      0,1,1,32'hD1, 3,0,0,1);
        add(1,0,0,1,      0,1,1,32'hD2, 2,0,0,1);
        add(1,0,0,1,      0,1,1,32'hD3, 1,0,0,1);
        add(1,0,0,0,      0,0,0,0,      0,0,0,1);

        // 260-word streaming frame: counter saturates at 255
        add(1,1,32'd0,1, 1,0,0,0, 0,0,0,1);
        for (int i = 1; i < 260; i++) add(1,1,32'(i),1, 1,1,1,32'(i-1), 1,0,0,1);
        add(1,0,0,1,      0,1,1,32'd259, 1,0,0,1);
        add(1,0,0,0,      0,0,0,0,       0,1,255,0);
        add(1,0,0,0,      0,0,0,0,       0,0,255,0);

        foreach (vecs[i]) begin
            row = i;
            drive(vecs[i].rst_n, vecs[i].dc, vecs[i].bus, vecs[i].rdy);
            chk("ack",        32'(ack),        32'(vecs[i].ack));
            chk("rd_valid",   32'(rd_valid),   32'(vecs[i].valid));
            chk("level",      32'(level),      32'(vecs[i].level));
            chk("frame_done", 32'(frame_done), 32'(vecs[i].done));
            chk("frame_len",  32'(frame_len),  32'(vecs[i].len));
            chk("frame_err",  32'(frame_err),  32'(vecs[i].err));
            if (vecs[i].chk_data) chk("rd_data", rd_data, vecs[i].data);
        end

        // asynchronous reset mid-frame after two words
        row = -2;
        drive(1,1,32'hE1,0);
        chk("rst_seq_ack0", 32'(ack), 32'd1);
        drive(1,1,32'hE2,0);
        chk("rst_seq_ack1", 32'(ack), 32'd1);
        drive(1,1,32'hE3,0);
        chk("rst_seq_level2", 32'(level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_level", 32'(level),     32'd0);
        chk("rst_async_valid", 32'(rd_valid),  32'd0);
        chk("rst_async_ack",   32'(ack),       32'd0);
        chk("rst_async_len",   32'(frame_len), 32'd0);
        drive(1,0,0,0);
        for (int i = 0; i < 3; i++) begin
            drive(1,0,0,0);
            chk("rst_no_done", 32'(frame_done), 32'd0);
            chk("rst_empty",   32'(level),      32'd0);
        end
        drive(1,1,32'hF1,0);
        chk("post_rst_ack", 32'(ack), 32'd1);
        drive(1,0,0,0);
        chk("post_rst_data", rd_data, 32'hF1);
        drive(1,0,0,0);
        chk("post_rst_done", 32'(frame_done), 32'd1);
        chk("post_rst_len",  32'(frame_len),  32'd1);
        chk("post_rst_err",  32'(frame_err),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_frame_receiver.md
Name: bus_frame_receiver

Overview:
- Receiving end of the shared 32-bit tristate data bus. The Mealy driver block places words on the bus while its `dcontrol` is high.
- This block samples the bus on every clock where `dcontrol` is high and returns a same-cycle Mealy acknowledge.
- Each contiguous `dcontrol`-high run forms one frame. Captured words are buffered in a small FIFO and drained through a valid/ready port. Each frame closes with a length/status report.

Parameters:
- DATA_W, 32, bus and FIFO word width.
- DEPTH, 4, FIFO depth in words; power of two, at least 2.
- LEN_W, 8, width of the frame word counter and frame_len.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- bus, in, DATA_W, shared tristate bus; sampled only while dcontrol=1.
- dcontrol, in, 1, driver enable; high means bus carries a valid word this cycle.
- ack, out, 1, Mealy acknowledge: word on bus is accepted at this edge.
- rd_data, out, DATA_W, FIFO head word.
- rd_valid, out, 1, FIFO non-empty.
- rd_ready, in, 1, consumer pops the head when rd_valid && rd_ready.
- level, out, clog2(DEPTH)+1, current FIFO occupancy.
- frame_done, out, 1, one-cycle pulse when a frame ends.
- frame_len, out, LEN_W, words accepted in the last frame; held until the next frame_done.
- frame_err, out, 1, last frame overflowed; updated with frame_done.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, FIFO empty, level=0, rd_valid=0.
  - frame_done=0, frame_len=0, frame_err=0, word counter=0.
  - ack is forced to 0 while rst_n=0.
  - Reset mid-frame discards the FIFO contents and the partial frame; no frame_done is issued.
- can_push = (level<DEPTH) or (level==DEPTH and rd_valid and rd_ready). A push and a pop in the same cycle are both performed and level is unchanged.
- ack = dcontrol and can_push and (state!=DROP). This is combinational from inputs and state (Mealy); no other outputs are combinational.
- Push: on an edge with ack=1, the bus word is written to the FIFO tail and the counter increments, saturating at 2^LEN_W-1.
- FIFO is first-word-fall-through. A word pushed at edge k is visible on rd_data/rd_valid after edge k. Latency bus to rd_data is 1 cycle.
- States:
  - IDLE:
    - dcontrol=1 and can_push: push, counter=1, go to RECV.
    - dcontrol=1 and not can_push: counter=0, err=1, go to DROP.
  - RECV:
    - dcontrol=1 and can_push: push, stay.
    - dcontrol=1 and not can_push: err=1, go to DROP; this word and the rest of the frame are lost.
    - dcontrol=0: frame ends, go to IDLE.
  - DROP:
    - ack=0; stay while dcontrol=1.
    - dcontrol=0: frame ends, go to IDLE.
- Frame end:
  - On the edge leaving RECV or DROP, set frame_done=1 for exactly one cycle, frame_len=counter, frame_err=err.
  - Then clear counter and err.
  - A new frame may begin in the cycle immediately after frame end (dcontrol low for only one cycle). IDLE handles it normally.
- A single-cycle dcontrol pulse is a one-word frame.
- Bus value is ignored (no X/Z propagation into the FIFO) whenever ack=0.
- No pop when rd_valid=0, regardless of rd_ready.

Test Plan:
- Reset release, dcontrol=0, rd_ready=0 -> ack=0, rd_valid=0, level=0, frame_done=0 for 10 cycles.
- dcontrol=1 for 3 cycles with bus=0x11,0x22,0x33, rd_ready=0 -> ack=1 each cycle, level=3. frame_done pulses one cycle after dcontrol falls, with frame_len=3, frame_err=0. Pops return 0x11,0x22,0x33 in order.
- rd_ready=0, 6-word frame 0xA0..0xA5 -> ack=1 for 0xA0..0xA3, ack=0 from 0xA4. frame_len=4, frame_err=1. FIFO holds 0xA0..0xA3.
- FIFO full (level=4), rd_ready=1, dcontrol=1 with bus=0xBB -> ack=1, simultaneous pop and push, level stays 4, 0xBB at the tail.
- Back-to-back frames (2 words, 1 idle cycle, 1 word) -> two frame_done pulses with frame_len=2 then 1, frame_err=0 both.
- rst_n=0 asserted asynchronously mid-frame after 2 words -> immediately level=0, rd_valid=0, ack=0. No frame_done after release. The next frame reports frame_len counting from 0.
